// File: rtl/race_pkg.sv
// Shared widths and FSM encoding for the race controller slice.
package race_pkg;

  localparam int X_W     = 8;
  localparam int Y_W     = 10;
  localparam int LIVES_W = 4;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CRASH = 2'd2,
    ST_GRACE = 2'd3
  } state_t;

endpackage

// File: rtl/race_controller_if.sv
// Game-logic <-> race controller signal bundle.
// The master drives positions/controls; the slave reports game status.
interface race_controller_if
  import race_pkg::*;
#(
  parameter int N_OBS = 6
);

  logic                   frame_tick;
  logic                   start;
  logic [X_W-1:0]         player_x;
  logic [Y_W-1:0]         player_y;
  logic [N_OBS-1:0]       obs_on;
  logic [X_W*N_OBS-1:0]   obs_x;
  logic [Y_W*N_OBS-1:0]   obs_y;

  logic                   alive;
  logic                   colision;
  logic [N_OBS-1:0]       hit_mask;
  logic [LIVES_W-1:0]     lives;
  logic [1:0]             state;
  logic                   game_over;

  modport master (
    output frame_tick, start, player_x, player_y, obs_on, obs_x, obs_y,
    input  alive, colision, hit_mask, lives, state, game_over
  );

  modport slave (
    input  frame_tick, start, player_x, player_y, obs_on, obs_x, obs_y,
    output alive, colision, hit_mask, lives, state, game_over
  );

endinterface

// File: rtl/race_controller_bbox_overlap.sv
// Combinational bounding-box overlap test for one player/obstacle pair.
// Differences are taken one bit wider and signed so that positions near
// opposite screen edges never appear close through wrap-around.
module bbox_overlap
  import race_pkg::*;
#(
  parameter int CAR_W = 16,
  parameter int CAR_H = 32
) (
  input  logic           obs_on,
  input  logic [X_W-1:0] player_x,
  input  logic [Y_W-1:0] player_y,
  input  logic [X_W-1:0] obs_x,
  input  logic [Y_W-1:0] obs_y,
  output logic           hit
);

  localparam logic [X_W:0] CW = (X_W+1)'(CAR_W);
  localparam logic [Y_W:0] CH = (Y_W+1)'(CAR_H);

  function automatic logic [X_W:0] abs_x(input logic signed [X_W:0] d);
    logic signed [X_W:0] neg;
    neg = -d;
    return d[X_W] ? neg : d;
  endfunction

  function automatic logic [Y_W:0] abs_y(input logic signed [Y_W:0] d);
    logic signed [Y_W:0] neg;
    neg = -d;
    return d[Y_W] ? neg : d;
  endfunction

  logic signed [X_W:0] dx;
  logic signed [Y_W:0] dy;
  logic        [X_W:0] adx;
  logic        [Y_W:0] ady;

  // Signed distance and magnitude along each axis, then the overlap test
  always_comb begin
    dx  = $signed({1'b0, player_x}) - $signed({1'b0, obs_x});
    dy  = $signed({1'b0, player_y}) - $signed({1'b0, obs_y});
    adx = abs_x(dx);
    ady = abs_y(dy);
    hit = obs_on & (adx < CW) & (ady < CH);
  end

endmodule

// File: rtl/race_controller.sv
// Race game controller: per-obstacle collision detection feeding a
// frame-paced IDLE/PLAY/CRASH/GRACE state machine with life accounting.
module race_controller
  import race_pkg::*;
#(
  parameter int N_OBS        = 6,
  parameter int LIVES        = 3,
  parameter int CRASH_FRAMES = 60,
  parameter int GRACE_FRAMES = 90,
  parameter int CAR_W        = 16,
  parameter int CAR_H        = 32
) (
  input  logic             clk,
  input  logic             reset,
  race_controller_if.slave bus
);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [CNT_W-1:0]   CRASH_INIT = CNT_W'(CRASH_FRAMES - 1);
  localparam logic [CNT_W-1:0]   GRACE_INIT =
    CNT_W'((GRACE_FRAMES == 0) ? 0 : GRACE_FRAMES - 1);

  logic [N_OBS-1:0]   hit_p0;
  logic [N_OBS-1:0]   hit_mask_p1;

  state_t             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               go_q, go_d;
  logic               col_q, col_d;

  // ---- stage p0: combinational overlap per obstacle channel ----
  for (genvar i = 0; i < N_OBS; i++) begin : g_obs
    bbox_overlap #(
      .CAR_W (CAR_W),
      .CAR_H (CAR_H)
    ) u_bbox (
      .obs_on   (bus.obs_on[i]),
      .player_x (bus.player_x),
      .player_y (bus.player_y),
      .obs_x    (bus.obs_x[X_W*i +: X_W]),
      .obs_y    (bus.obs_y[Y_W*i +: Y_W]),
      .hit      (hit_p0[i])
    );
  end

  // ---- stage p1: registered hit mask and FSM state ----
  // Register overlap flags and all game state; reset clears everything
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_mask_p1 <= '0;
      state_q     <= ST_IDLE;
      lives_q     <= '0;
      cnt_q       <= '0;
      go_q        <= 1'b0;
      col_q       <= 1'b0;
    end else begin
      hit_mask_p1 <= hit_p0;
      state_q     <= state_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      go_q        <= go_d;
      col_q       <= col_d;
    end
  end

  // Next-state logic: frame-paced except for start while idle
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    go_d    = go_q;
    col_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_PLAY;
          lives_d = LIVES_INIT;
          go_d    = 1'b0;
        end
      end
      ST_PLAY: begin
        // Any number of simultaneous hits costs a single life
        if (bus.frame_tick && (|hit_mask_p1)) begin
          state_d = ST_CRASH;
          col_d   = 1'b1;
          cnt_d   = CRASH_INIT;
          if (lives_q != '0) lives_d = lives_q - 1'b1;
        end
      end
      ST_CRASH: begin
        if (bus.frame_tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (lives_q != '0) begin
            if (GRACE_FRAMES == 0) begin
              state_d = ST_PLAY;
            end else begin
              state_d = ST_GRACE;
              cnt_d   = GRACE_INIT;
            end
          end else begin
            state_d = ST_IDLE;
            go_d    = 1'b1;
          end
        end
      end
      ST_GRACE: begin
        // Overlaps are ignored until the invulnerability window ends
        if (bus.frame_tick) begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else             state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.hit_mask  = hit_mask_p1;
  assign bus.state     = state_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = go_q;
  assign bus.colision  = col_q;
  assign bus.alive     = (state_q == ST_PLAY) || (state_q == ST_GRACE);

endmodule

// File: doc/race_controller.md
RACE_CONTROLLER -- requirements
Module: race_controller

Interface
REQ-001 Parameter N_OBS, default 6: number of obstacle channels checked (1..8).
REQ-002 Parameter LIVES, default 3: lives loaded at game start (1..15).
REQ-003 Parameter CRASH_FRAMES, default 60: frames spent in CRASH state (1..255).
REQ-004 Parameter GRACE_FRAMES, default 90: post-crash invulnerable frames (0..255).
REQ-005 Parameter CAR_W, default 16, and CAR_H, default 32: car bounding-box size in pixels, shared by player and obstacles.
REQ-006 clk  in  1  pixel/system clock; single clock domain.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 frame_tick  in  1  one-cycle pulse per game update (upsig).
REQ-009 start  in  1  level; begins or restarts a game.
REQ-010 player_x in 8, player_y in 10: player car top-left position.
REQ-011 obs_on in N_OBS, obs_x in 8*N_OBS, obs_y in 10*N_OBS: obstacle valid flags and packed positions; channel i occupies bits [8i+7:8i] and [10i+9:10i].
REQ-012 alive  out  1  high in PLAY and GRACE only.
REQ-013 colision  out  1  one-cycle pulse when a life is lost.
REQ-014 hit_mask  out  N_OBS  registered per-channel overlap flags.
REQ-015 lives  out  4  remaining lives.
REQ-016 state  out  2  IDLE=0, PLAY=1, CRASH=2, GRACE=3 (GAME_OVER reported as IDLE with game_over high).
REQ-017 game_over  out  1  high from last life lost until next start.

Function
REQ-018 Overlap for channel i SHALL be obs_on[i] AND |player_x-obs_x_i| < CAR_W AND |player_y-obs_y_i| < CAR_H, computed with 1-bit-extended signed differences (9 and 11 bits); no wrap-around.
REQ-019 hit_mask SHALL register the overlap vector every clock (latency 1), independent of state.
REQ-020 FSM SHALL advance only on frame_tick, except start handling in IDLE, which acts on any clock.
REQ-021 IDLE: start high -> PLAY, lives<=LIVES, game_over<=0.
REQ-022 PLAY: frame_tick with any hit_mask bit set -> CRASH, lives<=lives-1, colision pulses for exactly one cycle, frame counter<=CRASH_FRAMES-1.
REQ-023 Multiple simultaneous hits SHALL cost exactly one life.
REQ-024 CRASH: each frame_tick decrements counter; at frame_tick with counter 0 -> GRACE (counter<=GRACE_FRAMES-1) if lives>0, else IDLE with game_over<=1; if GRACE_FRAMES=0, go directly to PLAY.
REQ-025 GRACE: collisions ignored; frame_tick with counter 0 -> PLAY.
REQ-026 lives SHALL never underflow below 0.
REQ-027 start in PLAY, CRASH or GRACE SHALL be ignored; start held high through game over SHALL restart only after passing through IDLE (one clock minimum).
REQ-028 frame_tick and start asserted in the same IDLE cycle: start wins; first collision check occurs on the next frame_tick.

Reset
REQ-029 reset low at a clock edge SHALL force state=IDLE, lives=0, game_over=0, colision=0, alive=0, hit_mask=0, counter=0, effective the next cycle, including mid-CRASH/GRACE.

Structure
REQ-030 Package race_pkg SHALL hold state encodings, X_W=8, Y_W=10, LIVES_W=4, and CNT_W=8.
REQ-031 One sub-module bbox_overlap (one player/obstacle pair, combinational) SHALL be instantiated N_OBS times via generate.

Verification
REQ-032 Reset low 2 clocks, start=1 -> state=PLAY, lives=3, alive=1 next cycle.
REQ-033 player (100,400), obs0 (110,420) on, tick -> hit_mask=000001, colision 1-cycle pulse, lives=2, state=CRASH.
REQ-034 obs0 and obs3 both overlapping at same tick -> lives decrements by 1 only.
REQ-035 obs0 at (116,400) (dx=CAR_W) -> hit_mask=0, no crash; obs_on=0 with exact overlap -> no crash.
REQ-036 Third crash -> after 60 ticks state=IDLE, game_over=1, lives=0; overlap during GRACE (90 ticks) ignored.
REQ-037 reset low during CRASH counter=30 -> all outputs at reset values next cycle.
